// File: rtl/aes_state_collector_if.sv
// Column-in / block-out handshake bundle for the AES state collector.
// The slave modport is the collector's view; the master modport drives it.
interface aes_state_collector_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 2
);
  logic                    col_valid;
  logic                    col_ready;
  logic [DATA_WIDTH-1:0]   col_data;
  logic                    col_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*DATA_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    err;

  modport master (
    output col_valid, col_data, col_last, out_ready,
    input  col_ready, out_valid, out_data, out_count, err
  );

  modport slave (
    input  col_valid, col_data, col_last, out_ready,
    output col_ready, out_valid, out_data, out_count, err
  );
endinterface

// File: rtl/aes_state_collector.sv
// Packs four 32-bit AES columns into a 128-bit state block and queues completed
// blocks in a small circular FIFO behind a valid/ready output.
module aes_state_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_W      = 2
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    flush,
  aes_state_collector_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [4*DATA_WIDTH-1:0] block_t;

  logic [1:0]            col_idx_q, col_idx_d;
  logic [DATA_WIDTH-1:0] slot_q [3];
  block_t                mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;

  logic empty, full, col_ready, pop, accept, push;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop    = !empty && bus.out_ready && !flush;
  // Only the completing column can stall; a same-cycle pop frees the slot it needs.
  assign col_ready = flush || (col_idx_q != 2'd3) || !full || (!empty && bus.out_ready);
  assign accept = bus.col_valid && col_ready && !flush;
  assign push   = accept && (col_idx_q == 2'd3);

  always_comb begin
    col_idx_d = col_idx_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    if (flush) begin
      col_idx_d = 2'd0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      err_d     = 1'b0;
    end else begin
      if (accept) begin
        if (col_idx_q == 2'd3) begin
          col_idx_d = 2'd0;
          if (!bus.col_last) err_d = 1'b1;
        end else if (bus.col_last) begin
          // Early last: drop the partial block and resynchronise on column 0.
          col_idx_d = 2'd0;
          err_d     = 1'b1;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx_q <= 2'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      col_idx_q <= col_idx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else if (accept) begin
      case (col_idx_q)
        2'd0:    slot_q[0] <= bus.col_data;
        2'd1:    slot_q[1] <= bus.col_data;
        2'd2:    slot_q[2] <= bus.col_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {slot_q[0], slot_q[1], slot_q[2], bus.col_data};
    end
  end

  assign bus.col_ready = col_ready;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_count = count_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_aes_state_collector.sv
// Self-checking bench for aes_state_collector: directed scenarios plus a randomized
// run compared against a queue-based model of the column/block stream.
module tb_aes_state_collector;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   failures = 0;

  aes_state_collector_if #(.DATA_WIDTH(DW), .CNT_W(CNT_W)) bus ();

  aes_state_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: queued blocks, columns gathered so far, sticky error.
  logic [127:0] m_fifo[$];
  logic [31:0]  m_cols[$];
  logic         m_err;

  logic [132:0] dut_vec;
  assign dut_vec = {bus.col_ready, bus.out_valid, bus.out_count, bus.err, bus.out_data};

  function automatic logic m_ready();
    return flush || (m_cols.size() != 3) || (m_fifo.size() < int'(DEPTH)) ||
           (m_fifo.size() != 0 && bus.out_ready);
  endfunction

  function automatic logic [132:0] m_vec();
    logic [127:0] head;
    head = (m_fifo.size() != 0) ? m_fifo[0] : 128'h0;
    return {m_ready(), m_fifo.size() != 0, CNT_W'(m_fifo.size()), m_err, head};
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_cols.delete();
    m_err = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic ordy,
                       input logic fl);
    bus.col_valid = v;
    bus.col_data  = d;
    bus.col_last  = l;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Advance the model with the inputs now applied, then clock the DUT.
  task automatic tick();
    logic rdy, pop;
    rdy = m_ready();
    pop = (m_fifo.size() != 0) && bus.out_ready;
    if (flush) begin
      model_clear();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (bus.col_valid && rdy) begin
        if (m_cols.size() == 3) begin
          m_fifo.push_back({m_cols[0], m_cols[1], m_cols[2], bus.col_data});
          if (!bus.col_last) m_err = 1'b1;
          m_cols.delete();
        end else if (bus.col_last) begin
          m_err = 1'b1;
          m_cols.delete();
        end else begin
          m_cols.push_back(bus.col_data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    model_clear();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_count !== 2'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    checks++; if (bus.out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (bus.col_ready !== 1'b1) begin failures++; $display("FAIL reset_col_ready got=%0b exp=1", bus.col_ready); end
    @(posedge clk);
    #1;
    checks++; if (dut_vec !== m_vec()) begin failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, m_vec()); end
  endtask

  task automatic test_single_block();
    logic [31:0] c[4];
    c = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, c[i], i == 3, 1'b1, 1'b0);
      #2;
      checks++; if ({bus.col_ready, bus.out_valid} !== 2'b10) begin failures++; $display("FAIL single_col%0d ready/valid got=%b exp=10", i, {bus.col_ready, bus.out_valid}); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #2;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL single_out_data got=%h exp=00112233445566778899aabbccddeeff", bus.out_data); end
    tick();
    #2;
    checks++; if ({bus.out_valid, bus.out_count} !== 3'b000) begin failures++; $display("FAIL single_popped got=%b exp=000", {bus.out_valid, bus.out_count}); end
  endtask

  task automatic test_backpressure();
    logic [31:0]  c[12];
    logic [127:0] blk[3];
    for (int i = 0; i < 12; i++) c[i] = $urandom;
    for (int k = 0; k < 3; k++) blk[k] = {c[4*k], c[4*k+1], c[4*k+2], c[4*k+3]};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, c[i], (i % 4) == 3, 1'b0, 1'b0);
      #2;
      checks++; if (bus.col_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_col%0d got=%0b exp=1", i, bus.col_ready); end
      tick();
    end
    drive(1'b1, c[11], 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      #2;
      checks++; if ({bus.col_ready, bus.out_count} !== 3'b010) begin failures++; $display("FAIL bp_stall got=%b exp=010", {bus.col_ready, bus.out_count}); end
      tick();
    end
    drive(1'b1, c[11], 1'b1, 1'b1, 1'b0);
    #2;
    checks++; if ({bus.col_ready, bus.out_data} !== {1'b1, blk[0]}) begin failures++; $display("FAIL bp_release got=%h exp=%h", {bus.col_ready, bus.out_data}, {1'b1, blk[0]}); end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 3; k++) begin
      #2;
      checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, blk[k]}) begin failures++; $display("FAIL bp_order_blk%0d got=%h exp=%h", k, {bus.out_valid, bus.out_data}, {1'b1, blk[k]}); end
      tick();
    end
    #2;
    checks++; if ({bus.out_valid, bus.out_count} !== 3'b000) begin failures++; $display("FAIL bp_drained got=%b exp=000", {bus.out_valid, bus.out_count}); end
  endtask

  task automatic test_full_simultaneous();
    logic [31:0]  c[12];
    logic [127:0] blk[3];
    for (int i = 0; i < 12; i++) c[i] = $urandom;
    for (int k = 0; k < 3; k++) blk[k] = {c[4*k], c[4*k+1], c[4*k+2], c[4*k+3]};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, c[i], (i % 4) == 3, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, c[11], 1'b1, 1'b1, 1'b0);
    #2;
    checks++; if ({bus.col_ready, bus.out_count} !== 3'b110) begin failures++; $display("FAIL full_both_ready got=%b exp=110", {bus.col_ready, bus.out_count}); end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++; if ({bus.out_count, bus.out_data} !== {2'd2, blk[1]}) begin failures++; $display("FAIL full_head_adv got=%h exp=%h", {bus.out_count, bus.out_data}, {2'd2, blk[1]}); end
    checks++; if (dut_vec !== m_vec()) begin failures++; $display("FAIL full_model got=%h exp=%h", dut_vec, m_vec()); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_framing();
    logic [31:0] d;
    logic        l;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      l = (i == 1) || (i == 5);
      drive(1'b1, d, l, 1'b1, 1'b0);
      #2;
      checks++; if (dut_vec !== m_vec()) begin failures++; $display("FAIL framing_cyc%0d got=%h exp=%h", i, dut_vec, m_vec()); end
      tick();
      if (i == 1) begin
        checks++; if ({bus.err, bus.out_valid} !== 2'b10) begin failures++; $display("FAIL framing_early_last got=%b exp=10", {bus.err, bus.out_valid}); end
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    checks++; if ({bus.err, bus.out_valid} !== 2'b11) begin failures++; $display("FAIL framing_missing_last got=%b exp=11", {bus.err, bus.out_valid}); end
    checks++; if (dut_vec !== m_vec()) begin failures++; $display("FAIL framing_end got=%h exp=%h", dut_vec, m_vec()); end
  endtask

  task automatic test_flush_reset();
    logic [31:0]  c[4];
    logic [127:0] exp_blk;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2; i++) begin
        drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        tick();
      end
      if (pass == 0) begin
        drive(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
        #2;
        checks++; if (bus.col_ready !== 1'b1) begin failures++; $display("FAIL flush_col_ready got=%0b exp=1", bus.col_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
      end
      checks++; if ({bus.out_valid, bus.out_count, bus.err} !== 4'b0000) begin failures++; $display("FAIL clear%0d_state got=%b exp=0000", pass, {bus.out_valid, bus.out_count, bus.err}); end
      for (int i = 0; i < 4; i++) c[i] = $urandom;
      exp_blk = {c[0], c[1], c[2], c[3]};
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, c[i], i == 3, 1'b0, 1'b0);
        tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      #2;
      checks++; if ({bus.out_count, bus.out_data} !== {2'd1, exp_blk}) begin failures++; $display("FAIL clear%0d_block got=%h exp=%h", pass, {bus.out_count, bus.out_data}, {2'd1, exp_blk}); end
      tick();
      #2;
      checks++; if ({bus.out_valid, bus.err} !== 2'b00) begin failures++; $display("FAIL clear%0d_after got=%b exp=00", pass, {bus.out_valid, bus.err}); end
    end
  endtask

  task automatic test_random();
    logic        hold;
    logic [31:0] d;
    logic        l;
    hold = 1'b0;
    d = 32'h0;
    l = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        d = $urandom;
        l = (m_cols.size() == 3) ^ ($urandom_range(0, 9) == 0);
      end
      drive(hold || ($urandom_range(0, 3) != 0), d, l, $urandom_range(0, 1) == 1,
            $urandom_range(0, 31) == 0);
      #2;
      checks++; if (dut_vec !== m_vec()) begin failures++; $display("FAIL random_cyc%0d got=%h exp=%h", n, dut_vec, m_vec()); end
      hold = bus.col_valid && !m_ready();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_full_simultaneous();
    test_framing();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
